alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, handshaked successor to the 8-op combinational ALU: full-width result register,
//  zero/carry/illegal flags, valid/ready on both sides. Sits between issue logic and writeback.
//  Single-cycle ops complete 1 clk after acceptance; optional iterative MUL takes multiple clks.
// PARAMETERS
//  WIDTH   32   operand/result width, >=4, power of 2
//  SHW     $clog2(WIDTH)   localparam: shift-amount bits taken from b[SHW-1:0]
// PORTS
//  clk        in   1      single clock, all logic on rising edge
//  rst_n      in   1      synchronous, active-low reset
//  in_valid   in   1      operand/opcode valid
//  in_ready   out  1      block can accept this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  opcode     in   4      0000 ADD,0001 SUB,0010 AND,0011 OR,0100 XOR,0101 SLT,0110 SLL,0111 SRL,1000 MUL
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  registered result
//  zero_flag  out  1      result == 0
//  carry_flag out  1      ADD carry-out / SUB borrow (a<b unsigned); 0 for all other ops
//  illegal    out  1      opcode not supported; result forced 0
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=IDLE, out_valid=0, result=0, all flags=0, MUL counter=0;
//    in_ready=0 combinationally while rst_n=0. Reset mid-MUL aborts, no result produced.
//  - FSM: IDLE -> (accept single-cycle op) IDLE with out_valid=1 next clk;
//    IDLE -> (accept MUL) BUSY; BUSY -> after WIDTH iterations -> IDLE with out_valid=1.
//  - in_ready = rst_n && state==IDLE && (!out_valid || out_ready). Accept = in_valid && in_ready.
//  - Output slot: out_valid set on completion, cleared on out_valid && out_ready with no new
//    completion same clk. Simultaneous drain + accept of single-cycle op: out_valid stays 1,
//    new result loaded (back-to-back throughput 1/clk). result/flags stable while out_valid && !out_ready.
//  - Arithmetic: WIDTH-bit wrap-around; ADD/SUB computed as WIDTH+1 bits, MSB -> carry_flag.
//    SLT unsigned, result = {WIDTH-1 zeros, a<b}. SLL/SRL use b[SHW-1:0] only, zero fill.
//  - zero_flag computed from the final registered result value (incl. illegal -> zero_flag=1).
//  - Opcodes 1001..1111 always illegal: illegal=1, result=0, 1-clk latency.
//  - in_valid while in_ready=0: ignored; upstream must hold a/b/opcode until accepted.
// CONFIGURATION
//  ALU_PIPE_MUL_EN defined: opcode 1000 = unsigned shift-add MUL, low WIDTH bits of a*b;
//    operands latched at acceptance, one partial-product step per clk, WIDTH clks in BUSY,
//    out_valid asserted WIDTH+1 clks after acceptance; in_ready=0 throughout BUSY.
//  ALU_PIPE_MUL_EN undefined: no BUSY state/multiplier logic; 1000 treated as illegal
//    (illegal=1, result=0, 1-clk latency).
// TESTING
//  1 Reset: hold rst_n=0 2 clks -> out_valid=0,result=0,flags=0,in_ready=0; release -> in_ready=1.
//  2 WIDTH=32 ADD a=FFFF_FFFF b=1 -> next clk out_valid=1,result=0,zero=1,carry=1;
//    SUB a=3 b=5 -> result=FFFF_FFFE,carry=1; SLT a=3 b=5 -> result=1.
//  3 SLL a=1 b=0x21 -> result=2 (b[4:0]=1); SRL a=8000_0000 b=31 -> result=1.
//  4 Back-pressure: out_ready=0, issue ADD 1+1 then XOR -> result=2 held, in_ready=0, XOR not
//    taken; raise out_ready -> ADD drained, XOR accepted same clk, XOR result next clk.
//  5 Streaming: 8 ops on consecutive clks with out_ready=1 -> 8 results on 8 consecutive clks, in order.
//  6 MUL (EN): a=1234 b=5678 -> in_ready=0 for 32 clks, result=7006652 at clk 33; reset at clk 10
//    of MUL -> no out_valid. Without EN: opcode 1000 -> illegal=1,result=0 next clk; 1111 illegal both builds.

Source files
------------

// File: rtl/alu_pipe.sv
// Handshaked ALU stage: registered result with zero/carry/illegal flags and valid/ready on both sides.
// Define ALU_PIPE_MUL_EN to enable the iterative shift-add multiplier on opcode 4'b1000.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             illegal
);
  localparam int SHW = $clog2(WIDTH);

  // Handshake: a beat transfers on a rising edge where valid && ready are both high.
  // in_ready never depends on in_valid; out_valid is held until out_ready takes it.
  logic             accept;
  logic             busy;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ill;
  logic             load;
  logic [WIDTH-1:0] ld_res;
  logic             ld_carry;
  logic             ld_ill;

  assign in_ready = rst_n && !busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ill   = 1'b0;
    case (opcode)
      4'b0000: begin alu_res = sum_ext[WIDTH-1:0];  alu_carry = sum_ext[WIDTH];  end
      4'b0001: begin alu_res = diff_ext[WIDTH-1:0]; alu_carry = diff_ext[WIDTH]; end
      4'b0010: alu_res = a & b;
      4'b0011: alu_res = a | b;
      4'b0100: alu_res = a ^ b;
      4'b0101: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b0110: alu_res = a << b[SHW-1:0];
      4'b0111: alu_res = a >> b[SHW-1:0];
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state, state_nxt;
  logic             is_mul;
  logic             mul_done;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] mul_a, mul_b, acc, acc_nxt;

  assign is_mul  = (opcode == 4'b1000);
  assign busy    = (state == BUSY);
  assign acc_nxt = mul_b[0] ? acc + mul_a : acc;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_done  = 1'b0;
    case (state)
      IDLE: if (accept && is_mul) state_nxt = BUSY;
      BUSY: if (cnt == SHW'(WIDTH - 1)) begin
        state_nxt = IDLE;
        mul_done  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One partial product per clock: multiplicand shifts left while multiplier bits shift out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      mul_a <= '0;
      mul_b <= '0;
      acc   <= '0;
    end else if (accept && is_mul) begin
      cnt   <= '0;
      mul_a <= a;
      mul_b <= b;
      acc   <= '0;
    end else if (busy) begin
      cnt   <= cnt + SHW'(1);
      mul_a <= mul_a << 1;
      mul_b <= mul_b >> 1;
      acc   <= acc_nxt;
    end
  end

  assign load     = (accept && !is_mul) || mul_done;
  assign ld_res   = mul_done ? acc_nxt : alu_res;
  assign ld_carry = mul_done ? 1'b0 : alu_carry;
  assign ld_ill   = mul_done ? 1'b0 : alu_ill;
`else
  assign busy     = 1'b0;
  assign load     = accept;
  assign ld_res   = alu_res;
  assign ld_carry = alu_carry;
  assign ld_ill   = alu_ill;
`endif

  // A new completion wins over a drain in the same clock, giving one result per clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      result     <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      illegal    <= 1'b0;
    end else if (load) begin
      out_valid  <= 1'b1;
      result     <= ld_res;
      zero_flag  <= (ld_res == '0);
      carry_flag <= ld_carry;
      illegal    <= ld_ill;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: driver tasks push hand-computed expectations, a monitor pops on each output beat.
module tb_alu_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [3:0]   opcode;
  logic         zero_flag, carry_flag, illegal;

  logic [W+2:0] exp_q[$];
  int           pop_cyc_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero_flag(zero_flag), .carry_flag(carry_flag), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: each output beat taken by the consumer is compared against the queue head.
  always @(negedge clk) begin
    logic [W+2:0] e;
    if (rst_n && out_valid && out_ready) begin
      pop_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result %0h with no expected entry", result);
      end else begin
        e = exp_q.pop_front();
        check("result", result, e[W-1:0]);
        check("zero_flag", zero_flag, e[W]);
        check("carry_flag", carry_flag, e[W+1]);
        check("illegal", illegal, e[W+2]);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] er, input logic ez, input logic ec, input logic ei,
                       input bit push);
    int n = 0;
    opcode = op; a = av; b = bv; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin n++; @(negedge clk); end
    if (!in_ready) check("accept_timeout", 0, 1);
    else if (push) exp_q.push_back({ei, ec, ez, er});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // op, a, b, result, zero, carry
  logic [3:0]   s_op [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
  logic [W-1:0] s_a  [8] = '{32'd10, 32'd20, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hAAAA_AAAA, 32'd5, 32'd3, 32'hF000_0000};
  logic [W-1:0] s_b  [8] = '{32'd20, 32'd10, 32'hFF00_FF00, 32'h0000_F0F0, 32'hAAAA_AAAA, 32'd3, 32'd4, 32'd28};
  logic [W-1:0] s_r  [8] = '{32'd30, 32'd10, 32'hF000_F000, 32'h0F0F_F0F0, 32'h0, 32'h0, 32'h30, 32'hF};
  logic         s_z  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; opcode = '0;
    // Reset held for two clocks
    idle(2);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {zero_flag, carry_flag, illegal}, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Arithmetic boundaries
    issue(4'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 1, 1, 0, 1);
    @(negedge clk);
    check("add_wrap_valid", out_valid, 1);
    @(posedge clk); #1;
    issue(4'h1, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 1, 0, 1);
    issue(4'h5, 32'd3, 32'd5, 32'h1, 0, 0, 0, 1);
    issue(4'h6, 32'd1, 32'h21, 32'h2, 0, 0, 0, 1);
    issue(4'h7, 32'h8000_0000, 32'd31, 32'h1, 0, 0, 0, 1);
    issue(4'h0, 32'h8000_0000, 32'h8000_0000, 32'h0, 1, 1, 0, 1);
    issue(4'h1, 32'd5, 32'd5, 32'h0, 1, 0, 0, 1);
    issue(4'hF, 32'd5, 32'd6, 32'h0, 1, 0, 1, 1);
    issue(4'h9, 32'd7, 32'd7, 32'h0, 1, 0, 1, 1);
`ifndef ALU_PIPE_MUL_EN
    issue(4'h8, 32'd1234, 32'd5678, 32'h0, 1, 0, 1, 1);
`endif
    idle(3);

    // Back-pressure: ADD result held, XOR waits until the drain
    out_ready = 1'b0;
    issue(4'h0, 32'd1, 32'd1, 32'd2, 0, 0, 0, 1);
    opcode = 4'h4; a = 32'hFF; b = 32'h0F; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_held", {out_valid, result}, {1'b1, 32'd2});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 1'b0, 32'hF0});
    @(negedge clk);
    check("bp_release_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_xor_next", {out_valid, result}, {1'b1, 32'hF0});
    idle(3);

    // Streaming: eight ops on consecutive clocks
    n = pop_cyc_q.size();
    for (int i = 0; i < 8; i++) issue(s_op[i], s_a[i], s_b[i], s_r[i], s_z[i], 1'b0, 1'b0, 1);
    idle(3);
    check("stream_count", pop_cyc_q.size() - n, 8);
    if (pop_cyc_q.size() - n == 8) check("stream_span", pop_cyc_q[n+7] - pop_cyc_q[n], 7);

`ifdef ALU_PIPE_MUL_EN
    issue(4'h8, 32'd1234, 32'd5678, 32'd7006652, 0, 0, 0, 1);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (out_valid) break;
      if (!in_ready) n++;
    end
    check("mul_busy_clks", n, 32);
    @(posedge clk); #1;
    // Reset during MUL aborts without a result
    issue(4'h8, 32'd3, 32'd3, 32'd0, 0, 0, 0, 0);
    idle(9);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    n = 0;
    repeat (40) begin @(negedge clk); if (out_valid) n++; end
    check("mul_abort_no_valid", n, 0);
`endif

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin n++; @(posedge clk); end
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
